// File: rtl/spi_fsm_pkg.sv
// Shared definitions for the SPI memory transaction controller.
package spi_fsm_pkg;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    GET_ADDR     = 3'd1,
    ADDR_LATCH   = 3'd2,
    READ_LOAD    = 3'd3,
    READ_SEND    = 3'd4,
    WRITE_RECV   = 3'd5,
    WRITE_COMMIT = 3'd6,
    DONE         = 3'd7
  } state_t;

  localparam logic RW_READ           = 1'b1;
  localparam int   DEFAULT_WIDTH     = 8;
  localparam int   DEFAULT_ADDR_BITS = 7;

endpackage

// File: rtl/spi_fsm_bit_counter.sv
// Clearable enable-counter; termCount flags the strobe that completes a byte.
module bit_counter #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic termCount
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0] count;

  // Count enabled strobes; clear has priority so entry into a counting state starts at zero.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign termCount = en && (count == LAST);

endmodule

// File: rtl/spi_fsm.sv
// SPI memory transaction controller: counts bits, decodes the command byte
// and sequences the address-latch, memory-write, parallel-load and MISO enables.
//
// state        | meaning
// IDLE         | chip not selected, waiting for cs_n low
// GET_ADDR     | shifting in the 7-bit address + R/W command byte
// ADDR_LATCH   | addr_we pulse, R/W bit decoded
// READ_LOAD    | sr_we pulse, memory read data loaded into shift register
// READ_SEND    | miso_buff on while the read byte is shifted out
// WRITE_RECV   | shifting in the write data byte
// WRITE_COMMIT | dm_we pulse, received byte written to memory
// DONE         | transaction complete, waiting for cs_n high
module spi_fsm
  import spi_fsm_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int ADDR_BITS = DEFAULT_ADDR_BITS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cs_n,
  input  logic             shift_strobe,
  input  logic [WIDTH-1:0] shift_reg_pout,
  output logic             addr_we,
  output logic             dm_we,
  output logic             sr_we,
  output logic             miso_buff
);

  localparam int RW_BIT = WIDTH - 1 - ADDR_BITS;

  state_t state;
  state_t nextState;
  logic   counting;
  logic   cntEn;
  logic   cntClear;
  logic   termCount;
  logic   rwBit;
  logic   unusedPout;

  // The address bits go to the address latch, not to this controller.
  assign unusedPout = ^shift_reg_pout[WIDTH-1:RW_BIT+1];
  assign rwBit      = shift_reg_pout[RW_BIT];

  assign counting = (state == GET_ADDR) || (state == READ_SEND) || (state == WRITE_RECV);
  assign cntEn    = shift_strobe && counting && !cs_n;
  // Holding the counter clear outside the counting states makes every entry start at zero.
  assign cntClear = cs_n || !counting;

  bit_counter #(.WIDTH(WIDTH)) uBitCounter (
    .clk      (clk),
    .reset    (reset),
    .clear    (cntClear),
    .en       (cntEn),
    .termCount(termCount)
  );

  // Next-state decode; a deasserted chip select aborts from any state.
  always_comb begin
    nextState = state;
    if (cs_n) begin
      nextState = IDLE;
    end else begin
      case (state)
        IDLE:         nextState = GET_ADDR;
        GET_ADDR:     if (termCount) nextState = ADDR_LATCH;
        ADDR_LATCH:   nextState = (rwBit == RW_READ) ? READ_LOAD : WRITE_RECV;
        READ_LOAD:    nextState = READ_SEND;
        READ_SEND:    if (termCount) nextState = DONE;
        WRITE_RECV:   if (termCount) nextState = WRITE_COMMIT;
        WRITE_COMMIT: nextState = DONE;
        DONE:         nextState = DONE;
        default:      nextState = IDLE;
      endcase
    end
  end

  // State register with Moore outputs decoded from the next state so they are registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      addr_we   <= 1'b0;
      dm_we     <= 1'b0;
      sr_we     <= 1'b0;
      miso_buff <= 1'b0;
    end else begin
      state     <= nextState;
      addr_we   <= (nextState == ADDR_LATCH);
      dm_we     <= (nextState == WRITE_COMMIT);
      sr_we     <= (nextState == READ_LOAD);
      miso_buff <= (nextState == READ_SEND);
    end
  end

endmodule

// File: tb/tb_spi_fsm.sv
// Directed bench for spi_fsm: write, read, aborts, reset mid-write, ignored strobes.
module tb_spi_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic       cs_n;
  logic       shift_strobe;
  logic [7:0] shift_reg_pout;
  logic       addr_we;
  logic       dm_we;
  logic       sr_we;
  logic       miso_buff;

  int nCompared = 0;
  int nMismatch = 0;
  int nAddr = 0, nDm = 0, nSr = 0, nMiso = 0, nMulti = 0;
  int bAddr, bDm, bSr, bMiso;

  spi_fsm dut (
    .clk           (clk),
    .reset         (reset),
    .cs_n          (cs_n),
    .shift_strobe  (shift_strobe),
    .shift_reg_pout(shift_reg_pout),
    .addr_we       (addr_we),
    .dm_we         (dm_we),
    .sr_we         (sr_we),
    .miso_buff     (miso_buff)
  );

  always #5 clk = ~clk;

  // Tally high cycles of each output, sampled away from the active edge.
  always @(negedge clk) begin
    if (addr_we) nAddr++;
    if (dm_we) nDm++;
    if (sr_we) nSr++;
    if (miso_buff) nMiso++;
    if ((32'(addr_we) + 32'(dm_we) + 32'(sr_we)) > 1) nMulti++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Two idle cycles then one strobe cycle; returns just after the capturing edge.
  task automatic pulse(input logic [7:0] pout);
    tick();
    tick();
    shift_reg_pout = pout;
    shift_strobe   = 1'b1;
    tick();
    shift_strobe   = 1'b0;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatch++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chkOuts(input string tag, input logic [3:0] exp);
    chk(tag, int'({addr_we, dm_we, sr_we, miso_buff}), int'(exp));
  endtask

  task automatic snap();
    bAddr = nAddr; bDm = nDm; bSr = nSr; bMiso = nMiso;
  endtask

  initial begin
    reset = 1'b1; cs_n = 1'b1; shift_strobe = 1'b0; shift_reg_pout = 8'h00;
    tick(); tick();
    chkOuts("reset_outs", 4'b0000);
    reset = 1'b0;
    tick();

    // Write transaction: addr 0x2B, W, then data 0xA5
    snap();
    cs_n = 1'b0;
    for (int i = 0; i < 7; i++) pulse(8'h56);
    chk("wr_addr_we_before8", int'(addr_we), 0);
    pulse(8'h56);
    chkOuts("wr_addr_latch", 4'b1000);
    // strobe coincident with ADDR_LATCH is ignored
    shift_strobe = 1'b1;
    tick();
    shift_strobe = 1'b0;
    chkOuts("wr_recv_entry", 4'b0000);
    for (int i = 0; i < 7; i++) pulse(8'hA5);
    chk("wr_dm_we_before8", int'(dm_we), 0);
    pulse(8'hA5);
    chkOuts("wr_commit", 4'b0100);
    tick();
    chkOuts("wr_done", 4'b0000);
    pulse(8'hA5);
    pulse(8'hA5);
    chkOuts("wr_done_strobes", 4'b0000);
    chk("wr_addr_pulses", nAddr - bAddr, 1);
    chk("wr_dm_pulses", nDm - bDm, 1);
    chk("wr_sr_pulses", nSr - bSr, 0);
    chk("wr_miso_cycles", nMiso - bMiso, 0);
    cs_n = 1'b1;
    tick();
    chkOuts("wr_idle", 4'b0000);

    // Read transaction: addr 0x2B, R
    snap();
    cs_n = 1'b0;
    for (int i = 0; i < 8; i++) pulse(8'h57);
    chkOuts("rd_addr_latch", 4'b1000);
    tick();
    chkOuts("rd_load", 4'b0010);
    tick();
    chkOuts("rd_send_entry", 4'b0001);
    for (int i = 0; i < 7; i++) pulse(8'h57);
    chk("rd_miso_after7", int'(miso_buff), 1);
    pulse(8'h57);
    chkOuts("rd_done", 4'b0000);
    pulse(8'h57);
    chk("rd_dm_pulses", nDm - bDm, 0);
    chk("rd_sr_pulses", nSr - bSr, 1);
    chk("rd_addr_pulses", nAddr - bAddr, 1);
    cs_n = 1'b1;
    tick();

    // Abort during address phase, then a fresh full command is required
    snap();
    cs_n = 1'b0;
    for (int i = 0; i < 4; i++) pulse(8'h57);
    cs_n = 1'b1;
    tick();
    chkOuts("ab_addr_idle", 4'b0000);
    chk("ab_addr_no_pulse", nAddr - bAddr, 0);
    cs_n = 1'b0;
    for (int i = 0; i < 7; i++) pulse(8'h56);
    chk("ab_addr_restart7", int'(addr_we), 0);
    pulse(8'h56);
    chk("ab_addr_restart8", int'(addr_we), 1);
    cs_n = 1'b1;
    tick();

    // Abort in READ_SEND after 3 strobes
    snap();
    cs_n = 1'b0;
    for (int i = 0; i < 8; i++) pulse(8'h57);
    tick();
    tick();
    for (int i = 0; i < 3; i++) pulse(8'h3C);
    chk("ab_rd_miso_on", int'(miso_buff), 1);
    cs_n = 1'b1;
    tick();
    chkOuts("ab_rd_idle", 4'b0000);
    chk("ab_rd_dm_pulses", nDm - bDm, 0);

    // Reset in WRITE_RECV with cs_n held low
    snap();
    cs_n = 1'b0;
    for (int i = 0; i < 8; i++) pulse(8'h56);
    tick();
    for (int i = 0; i < 4; i++) pulse(8'hA5);
    reset = 1'b1;
    tick();
    chkOuts("rst_wr_outs", 4'b0000);
    reset = 1'b0;
    for (int i = 0; i < 7; i++) pulse(8'hA5);
    chkOuts("rst_wr_after7", 4'b0000);
    pulse(8'hA5);
    chk("rst_wr_new_addr", int'(addr_we), 1);
    chk("rst_wr_dm_pulses", nDm - bDm, 0);
    cs_n = 1'b1;
    tick();
    tick();

    chk("enables_exclusive", nMulti, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule

// File: doc/spi_fsm.md
Name: spi_fsm

Overview:
Transaction controller for the SPI memory peripheral. It sits directly downstream of the 8-bit shift register and consumes its parallel output and the same shift strobe. It counts received bits, decodes the 7-bit address + R/W command byte, and sequences the address-latch, data-memory write, shift-register parallel-load and MISO-buffer enables. It owns no datapath; it drives the enables of the shift register, address latch, data memory and tri-state MISO buffer.

Parameters:
WIDTH, 8, shift-register / transaction byte width in bits
ADDR_BITS, 7, address bits in the command byte (bits WIDTH-1..1); bit 0 is R/W

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
cs_n  input  1  conditioned (synchronized, debounced) chip select, active low
shift_strobe  input  1  one-clk pulse; the same strobe that shifts the shift register
shift_reg_pout  input  WIDTH  shift register parallel output
addr_we  output  1  address-latch write enable, one-cycle pulse
dm_we  output  1  data-memory write enable, one-cycle pulse
sr_we  output  1  shift-register parallel-load enable, one-cycle pulse
miso_buff  output  1  MISO tri-state buffer enable

Behaviour:
- One clock; reset is synchronous and active-high. Reset -> state IDLE, bit counter 0, all outputs 0.
- Moore outputs, registered state: addr_we=1 only in ADDR_LATCH; sr_we=1 only in READ_LOAD; dm_we=1 only in WRITE_COMMIT; miso_buff=1 only in READ_SEND. All are 0 elsewhere.
- Bit counter: width clog2(WIDTH+1). It increments at a clk edge where shift_strobe=1 and state is GET_ADDR, WRITE_RECV or READ_SEND. It clears on every entry to those states.
- Priority at each edge: reset > cs_n=1 > state transition.
- cs_n=1 in any state: next state IDLE, counter cleared, all outputs 0 the following cycle. This is a mid-transaction abort; no pending pulse is issued.
- IDLE: cs_n=0 -> GET_ADDR. A strobe in the IDLE cycle is ignored.
- GET_ADDR: at the edge where shift_strobe=1 and counter==WIDTH-1 -> ADDR_LATCH. The shift register updates on that same edge.
- ADDR_LATCH (1 cycle, addr_we=1): sample shift_reg_pout[0]. 1 = read -> READ_LOAD; 0 = write -> WRITE_RECV.
- READ_LOAD (1 cycle, sr_we=1): the memory's combinational read of the newly latched address is loaded into the shift register. Next state READ_SEND.
- READ_SEND (miso_buff=1): after the WIDTH-th strobe -> DONE.
- WRITE_RECV: after the WIDTH-th strobe -> WRITE_COMMIT.
- WRITE_COMMIT (1 cycle, dm_we=1): shift_reg_pout is written to memory. Next state DONE.
- DONE: all outputs 0; strobes ignored; stays until cs_n=1 -> IDLE.
- Strobes arriving in ADDR_LATCH, READ_LOAD or WRITE_COMMIT are not counted. The upstream conditioner guarantees strobes are at least 3 clk cycles apart, so none are lost in normal operation.
- Latency: addr_we is high in the cycle immediately after the edge that captured the 8th command bit. sr_we follows 1 cycle later. dm_we is high in the cycle after the edge of the 8th data bit.
- At most one of addr_we/dm_we/sr_we is high in any cycle.

Decomposition:
- Shared package spi_fsm_pkg: state encoding constants (IDLE, GET_ADDR, ADDR_LATCH, READ_LOAD, READ_SEND, WRITE_RECV, WRITE_COMMIT, DONE; 3-bit), RW_READ=1, default WIDTH=8 and ADDR_BITS=7.
- One sub-module: bit_counter, a clearable enable-counter with a terminal-count flag (count==WIDTH-1 && en).

Test Plan:
- Write: reset, cs_n=0, 8 strobes with shift_reg_pout=8'b0101_0110 (addr 0x2B, W), then 8 strobes with pout=8'hA5 -> addr_we one pulse after strobe 8; dm_we one pulse after strobe 16; sr_we and miso_buff stay 0; DONE until cs_n=1.
- Read: cs_n=0, 8 strobes with pout=8'b0101_0111 (addr 0x2B, R) -> addr_we pulse, sr_we pulse exactly 1 cycle later, miso_buff=1 for the next 8 strobes, then 0; dm_we never asserted.
- Abort in address phase: cs_n=0, 4 strobes, cs_n=1 -> IDLE next cycle, no pulses. A new transaction then needs a full 8 strobes before addr_we.
- Abort in READ_SEND after 3 strobes: cs_n=1 -> miso_buff drops the next cycle, IDLE.
- Reset mid-WRITE_RECV with cs_n held 0 -> all outputs 0, IDLE, then GET_ADDR; dm_we never pulses for the aborted write.
- Strobes during DONE and coincident with ADDR_LATCH -> ignored: no extra pulses, counter unchanged.
